// File: rtl/ppl_hazard_ctrl_if.sv
// Control bundle between the 5-stage pipeline datapath (master) and its hazard controller (slave).
// Signal suffixes follow the controller's view: _i are hazard inputs, _o are pipeline-register controls.
interface ppl_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs1_i;
  logic [REG_ADDR_W-1:0] id_rs2_i;
  logic                  id_use_rs1_i;
  logic                  id_use_rs2_i;
  logic [REG_ADDR_W-1:0] ex_rd_i;
  logic                  ex_is_load_i;
  logic                  branch_taken_i;
  logic                  mem_access_i;
  logic                  halt_req_i;

  logic                  pc_en_o;
  logic                  if_id_en_o;
  logic                  id_ex_en_o;
  logic                  ex_mem_en_o;
  logic                  mem_wb_en_o;
  logic                  if_id_flush_o;
  logic                  id_ex_flush_o;
  logic                  ex_mem_flush_o;
  logic                  mem_wb_flush_o;
  logic                  halted_o;
  logic [CNT_W-1:0]      stall_cycles_o;

  modport master (
    output id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_is_load_i,
           branch_taken_i, mem_access_i, halt_req_i,
    input  pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
           halted_o, stall_cycles_o
  );

  modport slave (
    input  id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i, ex_rd_i, ex_is_load_i,
           branch_taken_i, mem_access_i, halt_req_i,
    output pc_en_o, if_id_en_o, id_ex_en_o, ex_mem_en_o, mem_wb_en_o,
           if_id_flush_o, id_ex_flush_o, ex_mem_flush_o, mem_wb_flush_o,
           halted_o, stall_cycles_o
  );
endinterface

// File: rtl/ppl_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, multi-cycle memory freezes,
// halt drain sequencing and a wrapping stall-cycle counter.
module ppl_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_LAT    = 3,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ppl_hazard_ctrl_if.slave  bus
);
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_DRAIN    = 2'd2;
  localparam logic [1:0] ST_HALTED   = 2'd3;

  localparam int                    WAIT_W    = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;
  localparam int                    WAIT_INIT = (MEM_LAT > 2) ? MEM_LAT - 2 : 0;
  localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_INIT[WAIT_W-1:0];
  localparam logic [2:0]            DRAIN_LEN = 3'd4;
  localparam logic [REG_ADDR_W-1:0] REG_X0    = '0;

  logic [1:0]        state_q, state_d;
  logic [1:0]        ret_q, ret_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [2:0]        drain_q, drain_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  logic       lu, freeze, advance;
  logic [1:0] eff_state;
  logic       pc_en, halted;
  logic [3:0] en, flush;  // [3]=IF/ID, [2]=ID/EX, [1]=EX/MEM, [0]=MEM/WB

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    state_d = state_q;
    ret_d   = ret_q;
    wait_d  = wait_q;
    drain_d = drain_q;
    pc_en   = 1'b0;
    halted  = 1'b0;
    en      = 4'b0000;
    flush   = 4'b0000;

    lu = bus.ex_is_load_i && (bus.ex_rd_i != REG_X0) &&
         ((bus.id_use_rs1_i && (bus.id_rs1_i == bus.ex_rd_i)) ||
          (bus.id_use_rs2_i && (bus.id_rs2_i == bus.ex_rd_i)));

    advance   = (state_q == ST_MEM_WAIT) && (wait_q == '0);
    eff_state = advance ? ret_q : state_q;
    freeze    = (((state_q == ST_RUN) || (state_q == ST_DRAIN)) && bus.mem_access_i && (MEM_LAT > 1)) ||
                ((state_q == ST_MEM_WAIT) && (wait_q != '0));

    if (freeze) begin
      // Every stage holds, so branch/load-use decisions wait for the advance cycle.
      if (state_q == ST_MEM_WAIT) begin
        wait_d = wait_q - WAIT_W'(1);
      end else begin
        ret_d   = state_q;
        state_d = ST_MEM_WAIT;
        wait_d  = WAIT_LOAD;
      end
    end else begin
      case (eff_state)
        ST_RUN: begin
          en      = 4'b1111;
          pc_en   = 1'b1;
          state_d = ST_RUN;
          if (bus.branch_taken_i) begin
            flush = 4'b1100;
          end else if (lu) begin
            pc_en = 1'b0;
            en[3] = 1'b0;
            flush = 4'b0100;
          end
          if (bus.halt_req_i) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LEN;
          end
        end
        ST_DRAIN: begin
          en      = 4'b1111;
          flush   = 4'b1000;
          drain_d = drain_q - 3'd1;
          if (bus.branch_taken_i) begin
            // Keep the redirect so the PC is correct when the core resumes.
            pc_en = 1'b1;
            flush = 4'b1100;
          end else if (lu) begin
            en[3]   = 1'b0;
            flush   = 4'b0100;
            drain_d = drain_q;
          end
          state_d = (drain_d == 3'd0) ? ST_HALTED : ST_DRAIN;
        end
        ST_HALTED: begin
          halted  = 1'b1;
          state_d = bus.halt_req_i ? ST_HALTED : ST_RUN;
        end
        default: state_d = ST_RUN;
      endcase
    end

    stall_d = (!pc_en && (state_q != ST_HALTED)) ? stall_q + 1'b1 : stall_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      ret_q   <= ST_RUN;
      wait_q  <= '0;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
      state_q <= state_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  // Controls are forced low for as long as reset is held, independent of the clock.
  assign bus.pc_en_o        = rst_n & pc_en;
  assign bus.if_id_en_o     = rst_n & en[3];
  assign bus.id_ex_en_o     = rst_n & en[2];
  assign bus.ex_mem_en_o    = rst_n & en[1];
  assign bus.mem_wb_en_o    = rst_n & en[0];
  assign bus.if_id_flush_o  = rst_n & flush[3];
  assign bus.id_ex_flush_o  = rst_n & flush[2];
  assign bus.ex_mem_flush_o = rst_n & flush[1];
  assign bus.mem_wb_flush_o = rst_n & flush[0];
  assign bus.halted_o       = rst_n & halted;
  assign bus.stall_cycles_o = stall_q;
endmodule

// File: tb/tb_ppl_hazard_ctrl.sv
// Directed bench for ppl_hazard_ctrl (MEM_LAT=3): hand-computed control vectors and stall counts.
module tb_ppl_hazard_ctrl;
  localparam int REG_ADDR_W = 5;
  localparam int MEM_LAT    = 3;
  localparam int CNT_W      = 32;

  // Packed view: {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
  //               if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, halted}
  localparam logic [9:0] V_ZERO   = 10'b0_0000_0000_0;
  localparam logic [9:0] V_RUN    = 10'b1_1111_0000_0;
  localparam logic [9:0] V_LU     = 10'b0_0111_0100_0;
  localparam logic [9:0] V_BR     = 10'b1_1111_1100_0;
  localparam logic [9:0] V_DRAIN  = 10'b0_1111_1000_0;
  localparam logic [9:0] V_HALTED = 10'b0_0000_0000_1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [CNT_W-1:0] exp_stall;

  ppl_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();

  ppl_hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] outs();
    return {bus.pc_en_o, bus.if_id_en_o, bus.id_ex_en_o, bus.ex_mem_en_o, bus.mem_wb_en_o,
            bus.if_id_flush_o, bus.id_ex_flush_o, bus.ex_mem_flush_o, bus.mem_wb_flush_o,
            bus.halted_o};
  endfunction

  // Inputs change just after the falling edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.id_rs1_i       = '0;
    bus.id_rs2_i       = '0;
    bus.id_use_rs1_i   = 1'b0;
    bus.id_use_rs2_i   = 1'b0;
    bus.ex_rd_i        = '0;
    bus.ex_is_load_i   = 1'b0;
    bus.branch_taken_i = 1'b0;
    bus.mem_access_i   = 1'b0;
    bus.halt_req_i     = 1'b0;
  endtask

  task automatic set_load_use(input logic [REG_ADDR_W-1:0] rd);
    bus.ex_is_load_i = 1'b1;
    bus.ex_rd_i      = rd;
    bus.id_rs2_i     = rd;
    bus.id_use_rs2_i = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #12;
    n_checks++;
    if (outs() !== V_ZERO) begin
      n_fail++; $display("FAIL reset_outs: got %b expected %b", outs(), V_ZERO);
    end
    n_checks++;
    if (bus.stall_cycles_o !== '0) begin
      n_fail++; $display("FAIL reset_stall: got %0d expected 0", bus.stall_cycles_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    exp_stall = '0;
  endtask

  task automatic test_no_hazard();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (outs() !== V_RUN) begin
        n_fail++; $display("FAIL no_hazard_c%0d: got %b expected %b", i, outs(), V_RUN);
      end
      step();
    end
    n_checks++;
    if (bus.stall_cycles_o !== exp_stall) begin
      n_fail++; $display("FAIL no_hazard_stall: got %0d expected %0d", bus.stall_cycles_o, exp_stall);
    end
  endtask

  task automatic test_load_use();
    set_load_use(5'd5);
    #1;
    n_checks++;
    if (outs() !== V_LU) begin
      n_fail++; $display("FAIL load_use: got %b expected %b", outs(), V_LU);
    end
    step();
    exp_stall = exp_stall + 1;
    idle_inputs();
    #1;
    n_checks++;
    if (bus.stall_cycles_o !== exp_stall) begin
      n_fail++; $display("FAIL load_use_stall: got %0d expected %0d", bus.stall_cycles_o, exp_stall);
    end
    // Destination x0 never creates a hazard.
    set_load_use(5'd0);
    #1;
    n_checks++;
    if (outs() !== V_RUN) begin
      n_fail++; $display("FAIL load_use_x0: got %b expected %b", outs(), V_RUN);
    end
    // Matching rs1 that the instruction does not read is not a hazard.
    idle_inputs();
    bus.ex_is_load_i = 1'b1;
    bus.ex_rd_i      = 5'd7;
    bus.id_rs1_i     = 5'd7;
    #1;
    n_checks++;
    if (outs() !== V_RUN) begin
      n_fail++; $display("FAIL load_use_unused_rs1: got %b expected %b", outs(), V_RUN);
    end
    bus.id_use_rs1_i = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_LU) begin
      n_fail++; $display("FAIL load_use_rs1: got %b expected %b", outs(), V_LU);
    end
    idle_inputs();
    step();
    n_checks++;
    if (bus.stall_cycles_o !== exp_stall) begin
      n_fail++; $display("FAIL load_use_x0_stall: got %0d expected %0d", bus.stall_cycles_o, exp_stall);
    end
  endtask

  task automatic test_mem_freeze(input logic br);
    bus.mem_access_i   = 1'b1;
    bus.branch_taken_i = br;
    #1;
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      n_checks++;
      if (outs() !== V_ZERO) begin
        n_fail++; $display("FAIL freeze_br%0d_c%0d: got %b expected %b", br, i, outs(), V_ZERO);
      end
      step();
      exp_stall = exp_stall + 1;
    end
    n_checks++;
    if (outs() !== (br ? V_BR : V_RUN)) begin
      n_fail++; $display("FAIL freeze_br%0d_advance: got %b expected %b", br, outs(), br ? V_BR : V_RUN);
    end
    step();
    idle_inputs();
    #1;
    n_checks++;
    if (bus.stall_cycles_o !== exp_stall) begin
      n_fail++; $display("FAIL freeze_br%0d_stall: got %0d expected %0d", br, bus.stall_cycles_o, exp_stall);
    end
    n_checks++;
    if (outs() !== V_RUN) begin
      n_fail++; $display("FAIL freeze_br%0d_after: got %b expected %b", br, outs(), V_RUN);
    end
  endtask

  task automatic test_halt();
    bus.halt_req_i = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_RUN) begin
      n_fail++; $display("FAIL halt_req_cycle: got %b expected %b", outs(), V_RUN);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (outs() !== V_DRAIN) begin
        n_fail++; $display("FAIL halt_drain_c%0d: got %b expected %b", i, outs(), V_DRAIN);
      end
      step();
      exp_stall = exp_stall + 1;
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (outs() !== V_HALTED) begin
        n_fail++; $display("FAIL halt_halted_c%0d: got %b expected %b", i, outs(), V_HALTED);
      end
      step();
    end
    n_checks++;
    if (bus.stall_cycles_o !== exp_stall) begin
      n_fail++; $display("FAIL halt_stall: got %0d expected %0d", bus.stall_cycles_o, exp_stall);
    end
    bus.halt_req_i = 1'b0;
    step();
    n_checks++;
    if (outs() !== V_RUN) begin
      n_fail++; $display("FAIL halt_resume: got %b expected %b", outs(), V_RUN);
    end
  endtask

  // Drain with a load-use hold, a branch, a memory freeze and an ignored halt_req drop.
  task automatic test_drain_hazards();
    bus.halt_req_i = 1'b1;
    step();
    bus.halt_req_i = 1'b0;
    set_load_use(5'd9);
    #1;
    n_checks++;
    if (outs() !== V_LU) begin
      n_fail++; $display("FAIL drain_lu: got %b expected %b", outs(), V_LU);
    end
    step();
    exp_stall = exp_stall + 1;
    idle_inputs();
    bus.branch_taken_i = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_BR) begin
      n_fail++; $display("FAIL drain_branch: got %b expected %b", outs(), V_BR);
    end
    step();
    bus.branch_taken_i = 1'b0;
    bus.mem_access_i   = 1'b1;
    #1;
    for (int i = 0; i < MEM_LAT - 1; i++) begin
      n_checks++;
      if (outs() !== V_ZERO) begin
        n_fail++; $display("FAIL drain_freeze_c%0d: got %b expected %b", i, outs(), V_ZERO);
      end
      step();
      exp_stall = exp_stall + 1;
    end
    n_checks++;
    if (outs() !== V_DRAIN) begin
      n_fail++; $display("FAIL drain_advance: got %b expected %b", outs(), V_DRAIN);
    end
    step();
    exp_stall = exp_stall + 1;
    bus.mem_access_i = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if (outs() !== V_DRAIN) begin
        n_fail++; $display("FAIL drain_tail_c%0d: got %b expected %b", i, outs(), V_DRAIN);
      end
      step();
      exp_stall = exp_stall + 1;
    end
    n_checks++;
    if (outs() !== V_HALTED) begin
      n_fail++; $display("FAIL drain_halted: got %b expected %b", outs(), V_HALTED);
    end
    n_checks++;
    if (bus.stall_cycles_o !== exp_stall) begin
      n_fail++; $display("FAIL drain_stall: got %0d expected %0d", bus.stall_cycles_o, exp_stall);
    end
    step();
    n_checks++;
    if (outs() !== V_RUN) begin
      n_fail++; $display("FAIL drain_resume: got %b expected %b", outs(), V_RUN);
    end
  endtask

  task automatic test_reset_mid_wait();
    bus.mem_access_i = 1'b1;
    step();
    n_checks++;
    if (outs() !== V_ZERO) begin
      n_fail++; $display("FAIL rst_mid_frozen: got %b expected %b", outs(), V_ZERO);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ((outs() !== V_ZERO) || (bus.stall_cycles_o !== '0)) begin
      n_fail++; $display("FAIL rst_mid_held: got %b/%0d expected %b/0", outs(), bus.stall_cycles_o, V_ZERO);
    end
    bus.mem_access_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (outs() !== V_RUN) begin
      n_fail++; $display("FAIL rst_mid_release: got %b expected %b", outs(), V_RUN);
    end
    step();
    n_checks++;
    if ((outs() !== V_RUN) || (bus.stall_cycles_o !== '0)) begin
      n_fail++; $display("FAIL rst_mid_run: got %b/%0d expected %b/0", outs(), bus.stall_cycles_o, V_RUN);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_stall = '0;
    test_reset();
    test_no_hazard();
    test_load_use();
    test_mem_freeze(1'b0);
    test_mem_freeze(1'b1);
    test_halt();
    test_drain_hazards();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
